// File: rtl/deinterleaver_top.sv
// Block deinterleaver for the QPSK receive chain.
// Bits are written at the deinterleaved address into ping-pong banks and read out in order.
module deinterleaver_top #(
  parameter int N_CBPS = 192,
  parameter int D      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_in,
  input  logic data_in,
  output logic ready_out,
  output logic valid_out,
  output logic data_out,
  input  logic ready_in
);

  localparam int R  = N_CBPS / D;
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int AW = $clog2(N_CBPS);

  logic [N_CBPS-1:0] bank0;
  logic [N_CBPS-1:0] bank1;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_bank;
  logic              rd_bank;
  logic [RW-1:0]     r;
  logic [CW-1:0]     c;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_addr;
  logic              wr_en;
  logic              rd_en;
  logic              r_last;
  logic              wr_last;
  logic              rd_last;

  assign ready_out = !full[wr_bank];
  assign valid_out = full[rd_bank];
  assign data_out  = rd_bank ? bank1[rd_ptr] : bank0[rd_ptr];

  assign wr_en   = valid_in && ready_out;
  assign rd_en   = valid_out && ready_in;
  assign r_last  = (r == RW'(R - 1));
  assign wr_last = wr_en && r_last && (c == CW'(D - 1));
  assign rd_last = rd_en && (rd_ptr == AW'(N_CBPS - 1));
  assign wr_addr = AW'(D * int'(r) + int'(c));

  // Set on block completion, clear on block drain; the two never hit the same bank.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  // Write counters, read pointer, bank flags and bank pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r       <= '0;
      c       <= '0;
      rd_ptr  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        if (r_last) begin
          r <= '0;
          if (c == CW'(D - 1)) begin
            c       <= '0;
            wr_bank <= !wr_bank;
          end else begin
            c <= c + 1'b1;
          end
        end else begin
          r <= r + 1'b1;
        end
      end
      if (rd_en) begin
        if (rd_last) begin
          rd_ptr  <= '0;
          rd_bank <= !rd_bank;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // Bank storage, not reset; contents only matter once a bank is flagged full.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) bank1[wr_addr] <= data_in;
      else         bank0[wr_addr] <= data_in;
    end
  end

endmodule
